// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - RV32I decode/issue stage feeding ALU operands and function select
// Optional macro ALU_ISSUE_SKID_EN: one-entry skid register with a flopped in_ready.
module alu_issue_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] srcA,
    output logic [XLEN-1:0] srcB,
    output logic [3:0]      alu_fun,
    output logic            illegal
);

    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_u;
    logic [XLEN-1:0] dec_a, dec_b;
    logic [3:0]      dec_fun;
    logic            dec_ill;
    logic            accept, out_free;

    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u = {instr[31:12], 12'h000};

    always_comb begin
        dec_fun = 4'b0000;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b0;
        case (instr[6:0])
            7'b0110011: begin
                dec_fun = {instr[30], f3};
                dec_a   = rs1_val;
                dec_b   = rs2_val;
                if (!(f7 == 7'b0000000 ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
                    dec_ill = 1'b1;
            end
            7'b0010011: begin
                dec_fun = {(f3 == 3'b101) ? instr[30] : 1'b0, f3};
                dec_a   = rs1_val;
                dec_b   = imm_i;
                if (f3 == 3'b001 && f7 != 7'b0000000)
                    dec_ill = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    dec_ill = 1'b1;
            end
            7'b0110111: begin
                dec_fun = 4'b1001;
                dec_a   = imm_u;
            end
            7'b0010111: begin
                dec_a = pc;
                dec_b = imm_u;
            end
            7'b0000011: begin
                dec_a = rs1_val;
                dec_b = imm_i;
            end
            7'b0100011: begin
                dec_a = rs1_val;
                dec_b = imm_s;
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal bundles still issue, but with neutral operands
        if (dec_ill) begin
            dec_fun = 4'b0000;
            dec_a   = '0;
            dec_b   = '0;
        end
    end

    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
    logic            skid_valid;
    logic            in_ready_r;
    logic [XLEN-1:0] skid_a, skid_b;
    logic [3:0]      skid_fun;
    logic            skid_ill;

    assign in_ready = in_ready_r;

    // in_ready_r always mirrors !skid_valid, but lives in its own flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            srcA       <= '0;
            srcB       <= '0;
            alu_fun    <= 4'b0000;
            illegal    <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_r <= 1'b1;
            skid_a     <= '0;
            skid_b     <= '0;
            skid_fun   <= 4'b0000;
            skid_ill   <= 1'b0;
        end else if (skid_valid) begin
            if (out_free) begin
                srcA       <= skid_a;
                srcB       <= skid_b;
                alu_fun    <= skid_fun;
                illegal    <= skid_ill;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
                in_ready_r <= 1'b1;
            end
        end else if (accept) begin
            if (out_free) begin
                srcA      <= dec_a;
                srcB      <= dec_b;
                alu_fun   <= dec_fun;
                illegal   <= dec_ill;
                out_valid <= 1'b1;
            end else begin
                skid_a     <= dec_a;
                skid_b     <= dec_b;
                skid_fun   <= dec_fun;
                skid_ill   <= dec_ill;
                skid_valid <= 1'b1;
                in_ready_r <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            srcA      <= '0;
            srcB      <= '0;
            alu_fun   <= 4'b0000;
            illegal   <= 1'b0;
        end else if (accept) begin
            srcA      <= dec_a;
            srcB      <= dec_b;
            alu_fun   <= dec_fun;
            illegal   <= dec_ill;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule
